// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low matrix keypad one column at a time and
// debounces the sampled frames into a 16-bit key level vector.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous, active-high reset
//   row[3:0]   - keypad row lines, active-low, asynchronous to clk
//   col[3:0]   - keypad column drive, active-low, exactly one bit low
//   keys[15:0] - debounced key levels, keys[c*4+r] = column c / row r, 1 = pressed
//   key_pulse  - one-cycle high on each 0->1 transition of a keys bit
//   frame_done - one-cycle strobe after column 3 has been sampled
module keypad_scan #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] keys,
    output logic [15:0] key_pulse,
    output logic        frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // stable_cnt counts matching frame pairs; it never needs to exceed this
    localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS - 1);
    // DEBOUNCE_SCANS identical frames = DEBOUNCE_SCANS-1 consecutive matches
    localparam logic [4:0] ACCEPT_RUN = 5'(DEBOUNCE_SCANS - 1);

    localparam logic [1:0] COL0 = 2'd0;
    localparam logic [1:0] COL1 = 2'd1;
    localparam logic [1:0] COL2 = 2'd2;
    localparam logic [1:0] COL3 = 2'd3;

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [15:0]      raw_q, raw_d;
    logic [15:0]      last_q, last_d;
    logic [3:0]       stable_q, stable_d;
    logic [15:0]      keys_q, keys_d;
    logic [15:0]      pulse_q, pulse_d;
    logic             frame_done_q, frame_done_d;
    logic             sample_s;
    logic             match_s;

    // Next-state logic: synchroniser, column scan, frame capture and debounce.
    always_comb begin
        sync1_d      = row;
        sync2_d      = sync1_q;
        div_cnt_d    = div_cnt_q;
        col_idx_d    = col_idx_q;
        raw_d        = raw_q;
        frame_done_d = 1'b0;
        last_d       = last_q;
        stable_d     = stable_q;
        keys_d       = keys_q;
        pulse_d      = 16'h0000;
        match_s      = 1'b0;

        // Sample the synchronised rows at the end of the column dwell.
        sample_s = (div_cnt_q == DIV_LAST);
        if (sample_s) begin
            raw_d[{col_idx_q, 2'b00} +: 4] = ~sync2_q;
            div_cnt_d    = '0;
            col_idx_d    = col_idx_q + 2'd1;
            frame_done_d = (col_idx_q == COL3);
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // Column drive follows the next column index so it is registered.
        case (col_idx_d)
            COL0:    col_d = 4'b1110;
            COL1:    col_d = 4'b1101;
            COL2:    col_d = 4'b1011;
            COL3:    col_d = 4'b0111;
            default: col_d = 4'b1110;
        endcase

        // raw_q holds the complete frame during the frame_done cycle.
        if (frame_done_q) begin
            match_s = (raw_q == last_q);
            last_d  = raw_q;
            if (match_s) begin
                if (stable_q >= STABLE_MAX) begin
                    stable_d = STABLE_MAX;
                end else begin
                    stable_d = stable_q + 4'd1;
                end
            end else begin
                stable_d = 4'd0;
            end
            if (match_s && (({1'b0, stable_q} + 5'd1) >= ACCEPT_RUN) && (raw_q != keys_q)) begin
                keys_d  = raw_q;
                pulse_d = raw_q & ~keys_q;
            end else begin
                keys_d  = keys_q;
                pulse_d = 16'h0000;
            end
        end else begin
            match_s = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 4'b1111;
            sync2_q      <= 4'b1111;
            div_cnt_q    <= '0;
            col_idx_q    <= COL0;
            col_q        <= 4'b1110;
            raw_q        <= 16'h0000;
            last_q       <= 16'h0000;
            stable_q     <= 4'd0;
            keys_q       <= 16'h0000;
            pulse_q      <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_cnt_q    <= div_cnt_d;
            col_idx_q    <= col_idx_d;
            col_q        <= col_d;
            raw_q        <= raw_d;
            last_q       <= last_d;
            stable_q     <= stable_d;
            keys_q       <= keys_d;
            pulse_q      <= pulse_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col        = col_q;
    assign keys       = keys_q;
    assign key_pulse  = pulse_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives a modelled 4x4 keypad into keypad_scan and compares
// every cycle against a frame-level reference model (a key state is accepted
// once the last DEBOUNCE_SCANS fully sampled frames are identical).
module tb_keypad_scan;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys;
    logic [15:0] key_pulse;
    logic        frame_done;
    logic [15:0] kp;

    int total;
    int bad;

    // Reference model state
    int          e;
    logic [15:0] snap;
    logic [15:0] m_keys;
    logic [15:0] m_pulse;
    logic [15:0] hist[$];

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .keys(keys),
        .key_pulse(key_pulse),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) row = row & ~kp[c*4 +: 4];
        end
    end

    // Model one clock edge. Column c of frame f is seen as the keypad state
    // two edges before its sample edge; after each complete frame the key
    // vector is accepted if the last DB frames (counting the all-zero state
    // left by reset) agree and differ from the current keys.
    function automatic void model_edge();
        bit same;
        int c;
        if (rst) begin
            e       = 0;
            snap    = 16'h0000;
            m_keys  = 16'h0000;
            m_pulse = 16'h0000;
            hist.delete();
            hist.push_back(16'h0000);
        end else begin
            e       = e + 1;
            m_pulse = 16'h0000;
            if (e % SD == SD - 2) begin
                c = (e / SD) % 4;
                snap[c*4 +: 4] = kp[c*4 +: 4];
            end
            if (e > 1 && e % FRAME == 1) begin
                hist.push_back(snap);
                if (hist.size() > DB) hist.delete(0);
                same = 1'b1;
                foreach (hist[i]) if (hist[i] !== snap) same = 1'b0;
                if (hist.size() == DB && same && snap != m_keys) begin
                    m_pulse = snap & ~m_keys;
                    m_keys  = snap;
                end
            end
        end
    endfunction

    function automatic logic [36:0] exp_vec();
        logic [3:0] one;
        logic [3:0] mc;
        one = 4'b0001;
        mc  = ~(one << ((e / SD) % 4));
        return {mc, m_keys, m_pulse, (e > 0 && e % FRAME == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        kp  = 16'($urandom);
        tick();
        tick();
        total++;
        if ({col, keys, key_pulse, frame_done} !== {4'b1110, 16'h0000, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL reset: got=%h want=%h", {col, keys, key_pulse, frame_done},
                     {4'b1110, 16'h0000, 16'h0000, 1'b0});
        end
        rst = 1'b0;
        kp  = 16'h0000;
    endtask

    task automatic test_idle();
        int fd_cnt;
        int pulse_cnt;
        fd_cnt = 0;
        pulse_cnt = 0;
        kp = 16'h0000;
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (frame_done) fd_cnt++;
            if (key_pulse != 16'h0000 || keys != 16'h0000) pulse_cnt++;
            total++;
            if ({col, keys, key_pulse, frame_done} !== exp_vec()) begin
                bad++;
                $display("FAIL idle e=%0d: got=%h want=%h", e, {col, keys, key_pulse, frame_done}, exp_vec());
            end
        end
        total++;
        if (fd_cnt != 3 || pulse_cnt != 0) begin
            bad++;
            $display("FAIL idle_counts: got fd=%0d active=%0d want fd=3 active=0", fd_cnt, pulse_cnt);
        end
    endtask

    task automatic test_hold_key();
        int first_e;
        int pulse_cnt;
        first_e = -1;
        pulse_cnt = 0;
        kp = 16'h0200;
        do_reset();
        for (int i = 0; i < 13 * FRAME; i++) begin
            tick();
            if (first_e < 0 && keys == 16'h0200) first_e = e;
            if (key_pulse != 16'h0000) pulse_cnt++;
            total++;
            if ({col, keys, key_pulse, frame_done} !== exp_vec()) begin
                bad++;
                $display("FAIL hold e=%0d: got=%h want=%h", e, {col, keys, key_pulse, frame_done}, exp_vec());
            end
        end
        total++;
        if (first_e != 3 * FRAME + 1 || pulse_cnt != 1 || keys !== 16'h0200) begin
            bad++;
            $display("FAIL hold_latency: got edge=%0d pulses=%0d keys=%h want edge=%0d pulses=1 keys=0200",
                     first_e, pulse_cnt, keys, 3 * FRAME + 1);
        end
    endtask

    task automatic test_bounce();
        int active;
        active = 0;
        kp = 16'h0000;
        do_reset();
        for (int i = 0; i < 12 * FRAME; i++) begin
            if (i < 8 * FRAME && i > 0 && i % 10 == 0) kp = kp ^ 16'h0200;
            if (i == 8 * FRAME) kp = 16'h0000;
            tick();
            if (key_pulse != 16'h0000 || keys != 16'h0000) active++;
            total++;
            if ({col, keys, key_pulse, frame_done} !== exp_vec()) begin
                bad++;
                $display("FAIL bounce e=%0d: got=%h want=%h", e, {col, keys, key_pulse, frame_done}, exp_vec());
            end
        end
        total++;
        if (active != 0) begin
            bad++;
            $display("FAIL bounce_quiet: got active cycles=%0d want 0", active);
        end
    endtask

    task automatic test_two_keys();
        int pulse_cnt;
        logic [15:0] seen;
        pulse_cnt = 0;
        seen = 16'h0000;
        kp = 16'h8001;
        do_reset();
        for (int i = 0; i < 10 * FRAME; i++) begin
            if (i == 5 * FRAME) kp = 16'h8000;
            tick();
            if (key_pulse != 16'h0000) begin
                pulse_cnt++;
                seen = key_pulse;
            end
            total++;
            if ({col, keys, key_pulse, frame_done} !== exp_vec()) begin
                bad++;
                $display("FAIL two_keys e=%0d: got=%h want=%h", e, {col, keys, key_pulse, frame_done}, exp_vec());
            end
        end
        total++;
        if (pulse_cnt != 1 || seen !== 16'h8001 || keys !== 16'h8000) begin
            bad++;
            $display("FAIL two_keys_final: got pulses=%0d pulse=%h keys=%h want 1 8001 8000",
                     pulse_cnt, seen, keys);
        end
    endtask

    task automatic test_reset_mid_dwell();
        int first_e;
        first_e = -1;
        kp = 16'h0200;
        do_reset();
        for (int i = 0; i < 4 * FRAME; i++) tick();
        for (int i = 0; i < FRAME && (e % FRAME) != 2 * SD + 1; i++) tick();
        total++;
        if (col !== 4'b1011 || keys !== 16'h0200) begin
            bad++;
            $display("FAIL mid_dwell_setup: got col=%b keys=%h want col=1011 keys=0200", col, keys);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({col, keys, key_pulse, frame_done} !== {4'b1110, 16'h0000, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL mid_dwell_reset: got=%h want=%h", {col, keys, key_pulse, frame_done},
                     {4'b1110, 16'h0000, 16'h0000, 1'b0});
        end
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            if (first_e < 0 && key_pulse == 16'h0200) first_e = e;
            total++;
            if ({col, keys, key_pulse, frame_done} !== exp_vec()) begin
                bad++;
                $display("FAIL mid_dwell e=%0d: got=%h want=%h", e, {col, keys, key_pulse, frame_done}, exp_vec());
            end
        end
        total++;
        if (first_e != 3 * FRAME + 1) begin
            bad++;
            $display("FAIL mid_dwell_reaccept: got pulse edge=%0d want %0d", first_e, 3 * FRAME + 1);
        end
    endtask

    task automatic test_reset_on_frame_edge();
        kp = 16'h0421;
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++) tick();
        for (int i = 0; i < FRAME && (e % FRAME) != FRAME - 1; i++) tick();
        total++;
        if (col !== 4'b0111) begin
            bad++;
            $display("FAIL frame_edge_setup: got col=%b want 0111", col);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({col, keys, key_pulse, frame_done} !== {4'b1110, 16'h0000, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL frame_edge_reset: got=%h want=%h", {col, keys, key_pulse, frame_done},
                     {4'b1110, 16'h0000, 16'h0000, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        kp = 16'h0000;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            kp   = 16'($urandom) & 16'($urandom) & 16'($urandom);
            hold = int'($urandom_range(1, 5 * FRAME));
            for (int i = 0; i < hold; i++) begin
                if ($urandom_range(0, 19) == 0) kp = kp ^ (16'h0001 << $urandom_range(0, 15));
                tick();
                total++;
                if ({col, keys, key_pulse, frame_done} !== exp_vec()) begin
                    bad++;
                    $display("FAIL random e=%0d: got=%h want=%h", e, {col, keys, key_pulse, frame_done}, exp_vec());
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        kp    = 16'h0000;
        e     = 0;
        test_reset();
        test_idle();
        test_hold_key();
        test_bounce();
        test_two_keys();
        test_reset_mid_dwell();
        test_reset_on_frame_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and debounces it into the 16-bit `keys` level vector consumed by main_ctrl.
- Drives one active-low column at a time and samples the active-low rows through a synchroniser.
- Presents a key state only after it has been identical for several full scan frames.
- Also gives a one-cycle press pulse per key, for consumers that need edges.

Parameters:
- SCAN_DIV, 16, clock cycles each column is driven before sampling; legal range >= 4.
- DEBOUNCE_SCANS, 3, consecutive identical full frames required to accept a new key state; legal range >= 2, <= 15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- row  input  4  keypad row lines, active-low, asynchronous to clk
- col  output  4  keypad column drive, active-low, exactly one bit low
- keys  output  16  debounced key levels; keys[c*4+r] = key at column c, row r; 1 = pressed
- key_pulse  output  16  one-cycle high on the 0->1 edge of each keys bit
- frame_done  output  1  one-cycle strobe after column 3 has been sampled

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (on any edge with rst=1, including mid-scan):
  - col=4'b1110, keys=0, key_pulse=0, frame_done=0.
  - div_cnt=0, col_idx=0, raw frame=0, last_frame=0, stable_cnt=0, synchroniser=4'b1111.
  - Reset dominates all other events.
- Synchroniser:
  - row passes through 2 flops; row_s = 2nd stage.
  - Raw pressed bits = ~row_s.
- Column state machine, 4 states COL0..COL3 = col_idx:
  - col = ~(4'b0001 << col_idx).
  - div_cnt counts 0..SCAN_DIV-1.
  - On the edge where div_cnt==SCAN_DIV-1 (the sample edge):
    - raw[col_idx*4 +: 4] <= ~row_s.
    - div_cnt <= 0.
    - col_idx <= col_idx+1, wrapping 3->0.
  - If col_idx was 3 at that edge, frame_done is high for exactly the next cycle.
  - Frame period = 4*SCAN_DIV cycles.
  - The SCAN_DIV>=4 constraint covers the 2-cycle synchroniser plus settling.
- Debounce, evaluated only in the cycle frame_done=1:
  - match = (raw == last_frame).
  - last_frame <= raw.
  - If match: stable_cnt <= min(stable_cnt+1, DEBOUNCE_SCANS-1). Else: stable_cnt <= 0.
  - Accept when match && stable_cnt+1 >= DEBOUNCE_SCANS-1 && raw != keys.
  - On accept: keys <= raw and key_pulse <= raw & ~keys, both visible the cycle after frame_done.
  - key_pulse is 0 in every other cycle.
  - Releases (1->0) update keys but produce no pulse.
- Latency:
  - A clean press held across a full frame boundary appears on keys DEBOUNCE_SCANS frames after its first fully sampled frame, plus 1 cycle.
  - Worst case adds one extra frame for a press mid-frame.
- Boundary cases:
  - A partially sampled frame (key changes between column samples) is simply a non-matching frame.
  - Any change inside the window resets stable_cnt to 0. No partial updates.
  - Multiple simultaneous keys are reported as sampled. No ghost suppression.
  - stable_cnt saturates, so a key held indefinitely never wraps or re-pulses.
  - Reset in the middle of a column dwell restarts at COL0 with div_cnt=0. No pulse is emitted on the following accept unless keys actually changes from 0.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 16 cycles):
1. Reset, then idle with row=4'b1111 -> col walks 1110,1101,1011,0111, each for 4 cycles; frame_done pulses every 16 cycles; keys=0 and key_pulse=0 throughout.
2. Hold key (c=2, r=1): row[1]=0 whenever col==4'b1011, from reset release -> keys=16'h0200 one cycle after the 3rd frame_done; key_pulse=16'h0200 for exactly 1 cycle; no further pulses while held for 10 frames.
3. Bounce: toggle the same key every 10 cycles for 8 frames, then release -> keys stays 16'h0000 and no pulse ever.
4. Two keys (c0r0 and c3r3) held, then c0r0 released after 5 frames -> keys=16'h8001 with pulse 16'h8001; later keys=16'h8000 with no pulse.
5. Assert rst for 1 cycle mid-dwell of COL2 while key c2r1 is accepted -> next cycle col=4'b1110, keys=0; key re-accepted after 3 frames with pulse 16'h0200.
6. Reset and data change on the same edge: rst=1 while a frame is completing -> reset values win; frame_done stays 0 that cycle.
